scan_decoder: RTL and testbench

//  Parametrised, registered successor of the 2-to-4 decoder trio: decodes an SEL_W-bit code into

---
 rtl/scan_decoder.sv | 128 ++++++++++++
 tb/tb_scan_decoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : scan_decoder
//  Description : Registered SEL_W-bit code decoder producing three OUT_W-bit
//                forms (one-hot, active-low one-hot, thermometer), with a
//                manual load mode and a clocked auto-scan mode that steps the
//                code after a programmable dwell. Intended for digit/LED
//                multiplexing.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_decoder #(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    load,
  input  logic [SEL_W-1:0]        sel_in,
  output logic [SEL_W-1:0]        code_out,
  output logic [(1<<SEL_W)-1:0]   O1,
  output logic [(1<<SEL_W)-1:0]   O2,
  output logic [(1<<SEL_W)-1:0]   O3,
  output logic                    wrap
);

  localparam int OUT_W = 1 << SEL_W;

  // A one-bit counter is kept for DWELL=1 so the vector is never zero-width;
  // it then sits permanently at its terminal value and the code advances
  // every cycle.
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] CODE_LAST = {SEL_W{1'b1}};

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  state_t           nxt_state;
  logic [SEL_W-1:0] nxt_code;
  logic [CNT_W-1:0] nxt_cnt;
  logic             nxt_wrap;

  // One-hot decode of a code.
  function automatic logic [OUT_W-1:0] dec_onehot(input logic [SEL_W-1:0] c);
    logic [OUT_W-1:0] r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction

  // Thermometer decode: every bit at or below the code position is set.
  function automatic logic [OUT_W-1:0] dec_therm(input logic [SEL_W-1:0] c);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_W; i++) begin
      r[i] = (i <= int'(c));
    end
    return r;
  endfunction

  // Next-state, next-code, dwell counter and wrap pulse selection.
  always_comb begin
    nxt_state = state;
    nxt_code  = code_out;
    nxt_cnt   = '0;
    nxt_wrap  = 1'b0;
    if (!en) begin
      // Blank from any state; a coincident load is ignored.
      nxt_state = ST_BLANK;
    end else if (!mode) begin
      nxt_state = ST_MANUAL;
      if (load) begin
        nxt_code = sel_in;
      end
    end else begin
      nxt_state = ST_SCAN;
      // The entry cycle only clears the counter; stepping starts once the
      // machine is already scanning so the held code gets a full dwell.
      if (state == ST_SCAN) begin
        if (cnt == CNT_LAST) begin
          nxt_cnt  = '0;
          nxt_code = code_out + SEL_W'(1);
          nxt_wrap = (code_out == CODE_LAST);
        end else begin
          nxt_cnt = cnt + CNT_W'(1);
        end
      end
    end
  end

  // State, code and decoded outputs, all registered together so the three
  // output forms always describe the same code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_BLANK;
      code_out <= '0;
      cnt      <= '0;
      O1       <= '0;
      O2       <= '1;
      O3       <= '0;
      wrap     <= 1'b0;
    end else begin
      state    <= nxt_state;
      code_out <= nxt_code;
      cnt      <= nxt_cnt;
      wrap     <= nxt_wrap;
      if (nxt_state == ST_BLANK) begin
        O1 <= '0;
        O2 <= '1;
        O3 <= '0;
      end else begin
        O1 <= dec_onehot(nxt_code);
        O2 <= ~dec_onehot(nxt_code);
        O3 <= dec_therm(nxt_code);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_decoder
//  Description : Scoreboard bench for scan_decoder. Stimulus queues the
//                expected registered outputs after each clock edge; a monitor
//                pops and compares them shortly after the edge. A second
//                instance (SEL_W=3, DWELL=1) is checked for an 8-code walk and
//                for output consistency every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode, load;
  logic [1:0] sel_in;
  logic [1:0] code4;
  logic [3:0] o1_4, o2_4, o3_4;
  logic       wrap4;

  logic       en8, mode8, load8;
  logic [2:0] sel8;
  logic [2:0] code8;
  logic [7:0] o1_8, o2_8, o3_8;
  logic       wrap8;

  scan_decoder #(.SEL_W(2), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel_in(sel_in),
    .code_out(code4), .O1(o1_4), .O2(o2_4), .O3(o3_4), .wrap(wrap4)
  );

  scan_decoder #(.SEL_W(3), .DWELL(1)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .mode(mode8), .load(load8), .sel_in(sel8),
    .code_out(code8), .O1(o1_8), .O2(o2_8), .O3(o3_8), .wrap(wrap8)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         which;
    logic [2:0] code;
    logic [7:0] o1;
    logic [7:0] o2;
    logic [7:0] o3;
    logic       wrap;
    string      tag;
  } exp_t;

  exp_t q[$];

  // Expected outputs for a code; 'which' selects the 4-bit or 8-bit instance.
  function automatic exp_t mk(int which, int code, bit blank, bit wr, string tag);
    exp_t e;
    int   w;
    int   mask;
    int   o1;
    w      = (which != 0) ? 8 : 4;
    mask   = (1 << w) - 1;
    o1     = blank ? 0 : (1 << code);
    e.which = which;
    e.code  = 3'(code);
    e.o1    = 8'(o1);
    e.o2    = 8'((~o1) & mask);
    e.o3    = blank ? 8'd0 : 8'((1 << (code + 1)) - 1);
    e.wrap  = wr;
    e.tag   = tag;
    return e;
  endfunction

  function automatic logic [27:0] pack_exp(exp_t e);
    return {e.code, e.o1, e.o2, e.o3, e.wrap};
  endfunction

  function automatic logic [27:0] act4();
    return {1'b0, code4, 4'b0, o1_4, 4'b0, o2_4, 4'b0, o3_4, wrap4};
  endfunction

  function automatic logic [27:0] act8();
    return {code8, o1_8, o2_8, o3_8, wrap8};
  endfunction

  task automatic compare(string tag, logic [27:0] act, logic [27:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got code=%0d O1=%b O2=%b O3=%b wrap=%b, expected code=%0d O1=%b O2=%b O3=%b wrap=%b",
               tag, act[27:25], act[24:17], act[16:9], act[8:1], act[0],
               expv[27:25], expv[24:17], expv[16:9], expv[8:1], expv[0]);
    end
  endtask

  task automatic check_bit(string tag, logic act, logic expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, act, expv);
    end
  endtask

  // Monitor: compare every queued expectation shortly after the clock edge,
  // and check the 8-bit instance's output consistency every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.which == 0) compare(e.tag, act4(), pack_exp(e));
        else              compare(e.tag, act8(), pack_exp(e));
      end
      if (o1_8 != 8'd0) begin
        check_bit("inv_popcount", ($countones(o1_8) == 1), 1'b1);
        check_bit("inv_o2_not_o1", (o2_8 == ~o1_8), 1'b1);
        check_bit("inv_o3_therm", (int'(o3_8) == ((1 << (int'(code8) + 1)) - 1)), 1'b1);
      end else begin
        check_bit("inv_blank", (o2_8 == 8'hFF) && (o3_8 == 8'h00), 1'b1);
      end
    end
  end

  // One clock of stimulus for the 4-bit instance plus its expected result.
  task automatic cyc(bit r, bit e, bit m, bit l, int s, int ecode, bit eblank, bit ewrap, string tag);
    @(negedge clk);
    rst    = r;
    en     = e;
    mode   = m;
    load   = l;
    sel_in = 2'(s);
    @(posedge clk);
    q.push_back(mk(0, ecode, eblank, ewrap, tag));
  endtask

  task automatic cyc8(int ecode, bit ewrap);
    @(negedge clk);
    en8   = 1'b1;
    mode8 = 1'b1;
    load8 = 1'b0;
    @(posedge clk);
    q.push_back(mk(1, ecode, 1'b0, ewrap, "walk8"));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; sel_in = 2'd0;
    en8 = 1'b0; mode8 = 1'b0; load8 = 1'b0; sel8 = 3'd0;

    // Reset held, then released with en=0; en=0 with load must not load.
    cyc(1, 0, 0, 0, 0, 0, 1, 0, "reset_hold");
    cyc(1, 0, 0, 0, 0, 0, 1, 0, "reset_hold");
    cyc(0, 0, 0, 0, 0, 0, 1, 0, "blank_after_reset");
    cyc(0, 0, 0, 1, 3, 0, 1, 0, "en0_load_ignored");
    cyc(0, 0, 0, 0, 0, 0, 1, 0, "blank_after_reset");

    // Manual loads of every code, then holds while sel_in changes.
    for (int s = 0; s < 4; s++) begin
      cyc(0, 1, 0, 1, s, s, 0, 0, "manual_load");
      for (int h = 0; h < 9; h++) cyc(0, 1, 0, 0, (s + 1) % 4, s, 0, 0, "manual_hold");
    end

    // Auto-scan from code 0 with DWELL=4; load pulses must be ignored.
    cyc(0, 1, 0, 1, 0, 0, 0, 0, "manual_load0");
    for (int k = 0; k < 42; k++)
      cyc(0, 1, 1, (k % 3 == 1), k % 4, (k / 4) % 4, 0, (k > 0) && (k % 16 == 0), "scan");

    // Leave scan at code 2 mid-dwell, hold in manual, then resume scanning.
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0, 2, 0, 0, "scan_to_manual_hold");
    for (int k = 0; k < 6; k++) cyc(0, 1, 1, 0, 0, (2 + k / 4) % 4, 0, 0, "scan_resume");

    // Asynchronous reset at code 3: blank without a clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    compare("async_reset_immediate", act4(), pack_exp(mk(0, 0, 1, 0, "")));
    cyc(1, 1, 1, 0, 0, 0, 1, 0, "reset_mid_scan_hold");
    cyc(1, 1, 1, 0, 0, 0, 1, 0, "reset_mid_scan_hold");
    for (int k = 0; k < 6; k++) cyc(0, 1, 1, 0, 0, (k / 4) % 4, 0, 0, "scan_after_reset");

    // Blank keeps the code; manual re-displays it without a load.
    cyc(0, 0, 0, 1, 3, 1, 1, 0, "blank_holds_code");
    cyc(0, 1, 0, 0, 3, 1, 0, 0, "manual_redisplay");

    // 8-code walk with DWELL=1 on the second instance.
    for (int k = 0; k < 18; k++) cyc8(k % 8, (k > 0) && (k % 8 == 0));

    repeat (3) @(posedge clk);
    #2;
    check_bit("queue_drained", (q.size() == 0), 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
